// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register Normal/Stall/Flush modes for dmem waits, mul/div, branches and load-use.
// Optional perf counters (stall cycles, IF/ID flushes) are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_branch_taken_i,
  input  logic       ex_muldiv_start_i,
  input  logic       dmem_busy_i,
  output logic [1:0] pc_mode_o,
  output logic [1:0] if_id_mode_o,
  output logic [1:0] id_ex_mode_o,
  output logic [1:0] ex_mem_mode_o,
  output logic [1:0] mem_wb_mode_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_STALL  = 2'b01;
  localparam logic [1:0] MODE_FLUSH  = 2'b10;

  typedef enum logic {
    RUN,
    MULDIV
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;

  // ID reads a register the load in EX has not produced yet; x0 never creates a hazard.
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    pc_mode_o     = MODE_NORMAL;
    if_id_mode_o  = MODE_NORMAL;
    id_ex_mode_o  = MODE_NORMAL;
    ex_mem_mode_o = MODE_NORMAL;
    mem_wb_mode_o = MODE_NORMAL;
    if (rst_i) begin
      pc_mode_o     = MODE_FLUSH;
      if_id_mode_o  = MODE_FLUSH;
      id_ex_mode_o  = MODE_FLUSH;
      ex_mem_mode_o = MODE_FLUSH;
      mem_wb_mode_o = MODE_FLUSH;
    end else if (dmem_busy_i) begin
      pc_mode_o     = MODE_STALL;
      if_id_mode_o  = MODE_STALL;
      id_ex_mode_o  = MODE_STALL;
      ex_mem_mode_o = MODE_STALL;
      mem_wb_mode_o = MODE_FLUSH;
    end else if ((state == RUN && ex_muldiv_start_i) ||
                 (state == MULDIV && cnt != 4'd0)) begin
      // The mul/div holds EX; a bubble drains into MEM while WB retires normally.
      pc_mode_o     = MODE_STALL;
      if_id_mode_o  = MODE_STALL;
      id_ex_mode_o  = MODE_STALL;
      ex_mem_mode_o = MODE_FLUSH;
    end else if (state == MULDIV) begin
      // Release cycle: the finished result moves on, everything Normal.
      pc_mode_o     = MODE_NORMAL;
    end else if (ex_branch_taken_i) begin
      // Wrong-path instructions in IF and ID are squashed, which also masks any load-use.
      if_id_mode_o  = MODE_FLUSH;
      id_ex_mode_o  = MODE_FLUSH;
    end else if (load_use) begin
      pc_mode_o     = MODE_STALL;
      if_id_mode_o  = MODE_STALL;
      id_ex_mode_o  = MODE_FLUSH;
    end
  end

  // State register stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else if (!dmem_busy_i) begin
      case (state)
        RUN: begin
          if (ex_muldiv_start_i) begin
            state <= MULDIV;
            cnt   <= 4'(MULDIV_LAT - 1);
          end
        end
        MULDIV: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Perf counter stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= 32'd0;
      flush_events_o <= 32'd0;
    end else begin
      if (pc_mode_o == MODE_STALL)    stall_cycles_o <= stall_cycles_o + 32'd1;
      if (if_id_mode_o == MODE_FLUSH) flush_events_o <= flush_events_o + 32'd1;
    end
  end
`endif

endmodule
